// File: rtl/aurora_link_sequencer_pkg.sv
// State encoding, default bring-up durations and per-state control decode
// shared by the Aurora link sequencer and its bench.
package aurora_seq_pkg;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    PB_LEAD  = 4'd1,
    PMA_INIT = 4'd2,
    PB_LAG   = 4'd3,
    WAIT_UP  = 4'd4,
    DEBOUNCE = 4'd5,
    PERI_RST = 4'd6,
    RUN      = 4'd7,
    FAULT    = 4'd8
  } state_t;

  localparam int unsigned DefPbLeadCycles      = 1000;
  localparam int unsigned DefPmaInitCycles     = 75_000_000;
  localparam int unsigned DefPbLagCycles       = 25_000_000;
  localparam int unsigned DefLinkTimeoutCycles = 100_000_000;
  localparam int unsigned DefStableCycles      = 50_000;
  localparam int unsigned DefPeriResetCycles   = 50_000_000;
  localparam int unsigned DefMaxRetry          = 7;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // {reset_pb, pma_init, peri_reset} held while in state s
  function automatic logic [2:0] state_ctrl(input state_t s);
    case (s)
      PB_LEAD, PB_LAG:             return 3'b101;
      WAIT_UP, DEBOUNCE, PERI_RST: return 3'b001;
      RUN:                         return 3'b000;
      default:                     return 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/aurora_link_sequencer_if.sv
// Control and status wiring between the link sequencer and the Aurora core.
interface aurora_link_sequencer_if;
  logic aurora_reset_pb;
  logic aurora_pma_init;
  logic aurora_gt_pll_lock;
  logic aurora_channel_up;
  logic aurora_lane_up;

  modport master (
    output aurora_reset_pb,
    output aurora_pma_init,
    input  aurora_gt_pll_lock,
    input  aurora_channel_up,
    input  aurora_lane_up
  );

  modport slave (
    input  aurora_reset_pb,
    input  aurora_pma_init,
    output aurora_gt_pll_lock,
    output aurora_channel_up,
    output aurora_lane_up
  );
endinterface

// File: rtl/aurora_link_sequencer_sync_2ff.sv
// Two-flop synchroniser for slow asynchronous level signals; clears to 0 on reset.
module sync_2ff #(
  parameter int Width = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);
  logic [Width-1:0] r_meta;
  logic [Width-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;
endmodule

// File: rtl/aurora_link_sequencer.sv
// Aurora bring-up/recovery sequencer: orders reset_pb and pma_init, qualifies the
// link, releases the peripheral reset once stable, and retries with a bounded count.
module aurora_link_sequencer
  import aurora_seq_pkg::*;
#(
  parameter int unsigned PbLeadCycles      = DefPbLeadCycles,
  parameter int unsigned PmaInitCycles     = DefPmaInitCycles,
  parameter int unsigned PbLagCycles       = DefPbLagCycles,
  parameter int unsigned LinkTimeoutCycles = DefLinkTimeoutCycles,
  parameter int unsigned StableCycles      = DefStableCycles,
  parameter int unsigned PeriResetCycles   = DefPeriResetCycles,
  parameter int unsigned MaxRetry          = DefMaxRetry
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clk_locked,
  input  logic                    relink_req,
  aurora_link_sequencer_if.master aurora,
  output logic                    peri_reset,
  output logic                    link_ok,
  output logic                    fault,
  output logic [7:0]              retry_cnt,
  output logic [3:0]              state_o
);
  localparam int unsigned MaxCycles = max_u(max_u(max_u(PbLeadCycles, PmaInitCycles),
                                                  max_u(PbLagCycles, LinkTimeoutCycles)),
                                            max_u(StableCycles, PeriResetCycles));
  localparam int CntW = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;
  localparam logic [7:0] MaxRetryW = 8'(MaxRetry);

  state_t            r_state;
  state_t            w_state_next;
  logic [CntW-1:0]   r_cnt;
  logic [CntW-1:0]   w_cnt_next;
  logic [7:0]        r_retry;
  logic [7:0]        w_retry_next;
  logic              w_load;
  logic              w_fail;
  logic              w_cnt_done;
  logic [2:0]        w_status_sync;
  logic              w_stable;
  logic              r_reset_pb;
  logic              r_pma_init;
  logic              r_peri_reset;
  logic              r_link_ok;
  logic              r_fault;

  sync_2ff #(.Width(3)) u_status_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({aurora.aurora_gt_pll_lock, aurora.aurora_channel_up, aurora.aurora_lane_up}),
    .q     (w_status_sync)
  );

  assign w_stable   = &w_status_sync;
  assign w_cnt_done = (r_cnt == '0);

  // Counter preload on state entry: a timed state then lasts exactly N cycles.
  function automatic logic [CntW-1:0] load_value(input state_t s);
    case (s)
      PB_LEAD:  return CntW'(PbLeadCycles - 1);
      PMA_INIT: return CntW'(PmaInitCycles - 1);
      PB_LAG:   return CntW'(PbLagCycles - 1);
      WAIT_UP:  return CntW'(LinkTimeoutCycles - 1);
      DEBOUNCE: return CntW'(StableCycles - 1);
      PERI_RST: return CntW'(PeriResetCycles - 1);
      default:  return '0;
    endcase
  endfunction

  always_comb begin
    w_state_next = r_state;
    w_retry_next = r_retry;
    w_load       = 1'b0;
    w_fail       = 1'b0;
    if (!clk_locked) begin
      w_state_next = IDLE;
      w_retry_next = '0;
      w_load       = 1'b1;
    end else if (relink_req && (r_state != IDLE)) begin
      w_state_next = PB_LEAD;
      w_retry_next = '0;
      w_load       = 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_next = PB_LEAD;
          w_load       = 1'b1;
        end
        PB_LEAD:  if (w_cnt_done) begin w_state_next = PMA_INIT; w_load = 1'b1; end
        PMA_INIT: if (w_cnt_done) begin w_state_next = PB_LAG;   w_load = 1'b1; end
        PB_LAG:   if (w_cnt_done) begin w_state_next = WAIT_UP;  w_load = 1'b1; end
        WAIT_UP: begin
          if (w_stable) begin
            w_state_next = DEBOUNCE;
            w_load       = 1'b1;
          end else if (w_cnt_done) begin
            w_fail = 1'b1;
          end
        end
        DEBOUNCE: begin
          if (!w_stable) w_fail = 1'b1;
          else if (w_cnt_done) begin w_state_next = PERI_RST; w_load = 1'b1; end
        end
        PERI_RST: begin
          if (!w_stable) w_fail = 1'b1;
          else if (w_cnt_done) begin w_state_next = RUN; w_retry_next = '0; end
        end
        RUN:      if (!w_stable) w_fail = 1'b1;
        FAULT:    w_state_next = FAULT;
        default: begin
          w_state_next = IDLE;
          w_load       = 1'b1;
        end
      endcase
      // Exhausted retries park in FAULT without advancing the count.
      if (w_fail) begin
        if (r_retry >= MaxRetryW) begin
          w_state_next = FAULT;
        end else begin
          w_state_next = PB_LEAD;
          w_retry_next = r_retry + 8'd1;
          w_load       = 1'b1;
        end
      end
    end
    w_cnt_next = w_load ? load_value(w_state_next)
                        : (w_cnt_done ? r_cnt : r_cnt - CntW'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_retry      <= '0;
      r_reset_pb   <= 1'b1;
      r_pma_init   <= 1'b1;
      r_peri_reset <= 1'b1;
      r_link_ok    <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_retry      <= w_retry_next;
      {r_reset_pb, r_pma_init, r_peri_reset} <= state_ctrl(w_state_next);
      r_link_ok    <= (w_state_next == RUN);
      r_fault      <= (w_state_next == FAULT);
    end
  end

  assign aurora.aurora_reset_pb = r_reset_pb;
  assign aurora.aurora_pma_init = r_pma_init;
  assign peri_reset             = r_peri_reset;
  assign link_ok                = r_link_ok;
  assign fault                  = r_fault;
  assign retry_cnt              = r_retry;
  assign state_o                = r_state;
endmodule

// File: tb/tb_aurora_link_sequencer.sv
// Scoreboard bench: a phase/elapsed-time reference model predicts every state or
// retry-count change, and a monitor matches each DUT change against that queue.
module tb_aurora_link_sequencer;
  localparam int PB_LEAD_N = 4;
  localparam int PMA_N     = 10;
  localparam int LAG_N     = 6;
  localparam int TO_N      = 50;
  localparam int STB_N     = 8;
  localparam int PERI_N    = 5;
  localparam int MAX_RETRY = 2;

  localparam int S_IDLE = 0, S_PB_LEAD = 1, S_PMA_INIT = 2, S_PB_LAG = 3, S_WAIT_UP = 4;
  localparam int S_DEBOUNCE = 5, S_PERI_RST = 6, S_RUN = 7, S_FAULT = 8;

  // Output levels per state, straight from the state table.
  bit tab_pb   [9] = '{1, 1, 1, 1, 0, 0, 0, 0, 1};
  bit tab_pma  [9] = '{1, 0, 1, 0, 0, 0, 0, 0, 1};
  bit tab_peri [9] = '{1, 1, 1, 1, 1, 1, 1, 0, 1};

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       clk_locked = 1'b0;
  logic       relink_req = 1'b0;
  logic       peri_reset;
  logic       link_ok;
  logic       fault;
  logic [7:0] retry_cnt;
  logic [3:0] state_o;

  aurora_link_sequencer_if u_if ();

  aurora_link_sequencer #(
    .PbLeadCycles      (PB_LEAD_N),
    .PmaInitCycles     (PMA_N),
    .PbLagCycles       (LAG_N),
    .LinkTimeoutCycles (TO_N),
    .StableCycles      (STB_N),
    .PeriResetCycles   (PERI_N),
    .MaxRetry          (MAX_RETRY)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clk_locked (clk_locked),
    .relink_req (relink_req),
    .aurora     (u_if),
    .peri_reset (peri_reset),
    .link_ok    (link_ok),
    .fault      (fault),
    .retry_cnt  (retry_cnt),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int st;
    int ret;
  } txn_t;

  txn_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   m_state = S_IDLE;
  int   m_elapsed = 0;
  int   m_retry = 0;
  bit   hist[$];

  function automatic int dur(input int s);
    case (s)
      S_PB_LEAD:  return PB_LEAD_N;
      S_PMA_INIT: return PMA_N;
      S_PB_LAG:   return LAG_N;
      S_WAIT_UP:  return TO_N;
      S_DEBOUNCE: return STB_N;
      S_PERI_RST: return PERI_N;
      default:    return 0;
    endcase
  endfunction

  function automatic void push_txn(input int st, input int ret);
    txn_t t;
    t.cyc = cyc;
    t.st  = st;
    t.ret = ret;
    exp_q.push_back(t);
  endfunction

  function automatic void model_reset();
    if (m_state != S_IDLE || m_retry != 0) push_txn(S_IDLE, 0);
    m_state   = S_IDLE;
    m_retry   = 0;
    m_elapsed = 0;
    hist.delete();
    hist.push_back(1'b0);
    hist.push_back(1'b0);
  endfunction

  // One clock edge of the reference; link status reaches the sequencer two edges late.
  function automatic void model_edge(input bit locked, input bit relink, input bit raw);
    bit stab;
    bit fail;
    bit restart;
    bit dn;
    int nxt;
    int ret;
    stab = hist.pop_front();
    hist.push_back(raw);
    nxt = m_state;
    ret = m_retry;
    fail = 1'b0;
    restart = 1'b0;
    dn = (m_elapsed + 1 >= dur(m_state));
    if (!locked) begin
      nxt = S_IDLE;
      ret = 0;
    end else if (relink && m_state != S_IDLE) begin
      nxt = S_PB_LEAD;
      ret = 0;
      restart = 1'b1;
    end else begin
      case (m_state)
        S_IDLE:     nxt = S_PB_LEAD;
        S_PB_LEAD:  if (dn) nxt = S_PMA_INIT;
        S_PMA_INIT: if (dn) nxt = S_PB_LAG;
        S_PB_LAG:   if (dn) nxt = S_WAIT_UP;
        S_WAIT_UP:  if (stab) nxt = S_DEBOUNCE; else if (dn) fail = 1'b1;
        S_DEBOUNCE: if (!stab) fail = 1'b1; else if (dn) nxt = S_PERI_RST;
        S_PERI_RST: if (!stab) fail = 1'b1; else if (dn) begin nxt = S_RUN; ret = 0; end
        S_RUN:      if (!stab) fail = 1'b1;
        default:    nxt = m_state;
      endcase
      if (fail) begin
        if (m_retry >= MAX_RETRY) nxt = S_FAULT;
        else begin
          ret = m_retry + 1;
          nxt = S_PB_LEAD;
          restart = 1'b1;
        end
      end
    end
    m_elapsed = (nxt != m_state || restart) ? 0 : m_elapsed + 1;
    if (nxt != m_state || ret != m_retry) push_txn(nxt, ret);
    m_state = nxt;
    m_retry = ret;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d cyc=%0d", name, act, req, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    if (rst_n)
      model_edge(clk_locked, relink_req,
                 u_if.aurora_gt_pll_lock & u_if.aurora_channel_up & u_if.aurora_lane_up);
    #1;
    relink_req = 1'b0;
  endtask

  task automatic set_status(input bit pll, input bit ch, input bit ln);
    u_if.aurora_gt_pll_lock = pll;
    u_if.aurora_channel_up  = ch;
    u_if.aurora_lane_up     = ln;
  endtask

  task automatic wait_model(input int st, input int budget, input string tag);
    int n;
    n = 0;
    while (m_state != st && n < budget) begin
      step();
      n++;
    end
    if (m_state != st) begin
      checks++;
      errors++;
      $display("FAIL %s_wait actual_state=%0d required_state=%0d", tag, m_state, st);
    end
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_reset_pb"}, int'(u_if.aurora_reset_pb), 1);
    chk({tag, "_pma_init"}, int'(u_if.aurora_pma_init), 1);
    chk({tag, "_peri_reset"}, int'(peri_reset), 1);
    chk({tag, "_link_ok"}, int'(link_ok), 0);
    chk({tag, "_fault"}, int'(fault), 0);
    chk({tag, "_retry"}, int'(retry_cnt), 0);
    chk({tag, "_state"}, int'(state_o), S_IDLE);
  endtask

  task automatic async_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check_reset_outs(tag);
    model_reset();
    repeat (2) step();
    rst_n = 1'b1;
    chk({tag, "_release_state"}, int'(state_o), S_IDLE);
    step();
  endtask

  initial begin : monitor
    logic [3:0] prev_st;
    logic [7:0] prev_ret;
    logic [4:0] act_o;
    logic [4:0] req_o;
    txn_t       e;
    prev_st  = 4'd0;
    prev_ret = 8'd0;
    forever begin
      @(negedge clk);
      if (state_o != prev_st || retry_cnt != prev_ret) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL txn_unexpected actual state=%0d retry=%0d cyc=%0d required no change",
                   state_o, retry_cnt, cyc);
        end else begin
          e = exp_q.pop_front();
          if (int'(state_o) != e.st || int'(retry_cnt) != e.ret || cyc != e.cyc) begin
            errors++;
            $display("FAIL txn actual state=%0d retry=%0d cyc=%0d required state=%0d retry=%0d cyc=%0d",
                     state_o, retry_cnt, cyc, e.st, e.ret, e.cyc);
          end else begin
            $display("TXN cyc=%0d state=%0d retry=%0d", cyc, state_o, retry_cnt);
          end
          act_o = {u_if.aurora_reset_pb, u_if.aurora_pma_init, peri_reset, link_ok, fault};
          req_o = {tab_pb[e.st], tab_pma[e.st], tab_peri[e.st], e.st == S_RUN, e.st == S_FAULT};
          checks++;
          if (act_o != req_o) begin
            errors++;
            $display("FAIL txn_outputs actual=%05b required=%05b cyc=%0d", act_o, req_o, cyc);
          end
        end
        prev_st  = state_o;
        prev_ret = retry_cnt;
      end
    end
  end

  initial begin : driver
    bit peri_all;
    rst_n = 1'b0;
    set_status(1'b0, 1'b0, 1'b0);
    model_reset();
    #1;
    check_reset_outs("por");
    repeat (3) step();
    rst_n = 1'b1;
    repeat (3) step();
    chk("idle_unlocked", int'(state_o), S_IDLE);

    // Nominal bring-up with status raised from PB_LAG onward.
    clk_locked = 1'b1;
    wait_model(S_PB_LAG, 100, "nom_lag");
    set_status(1'b1, 1'b1, 1'b1);
    wait_model(S_RUN, 200, "nom_run");
    repeat (2) step();
    chk("nom_link_ok", int'(link_ok), 1);
    chk("nom_peri_reset", int'(peri_reset), 0);
    chk("nom_reset_pb", int'(u_if.aurora_reset_pb), 0);

    // Link loss in RUN.
    set_status(1'b1, 1'b1, 1'b0);
    repeat (3) step();
    chk("loss_peri_reset", int'(peri_reset), 1);
    chk("loss_link_ok", int'(link_ok), 0);
    chk("loss_retry", int'(retry_cnt), 1);
    chk("loss_state", int'(state_o), S_PB_LEAD);
    set_status(1'b1, 1'b1, 1'b1);
    wait_model(S_RUN, 200, "loss_recover");

    // One-cycle channel_up glitch on DEBOUNCE cycle 5.
    relink_req = 1'b1;
    step();
    wait_model(S_DEBOUNCE, 200, "glitch_deb");
    repeat (4) step();
    peri_all = 1'b1;
    set_status(1'b1, 1'b0, 1'b1);
    step();
    peri_all &= peri_reset;
    set_status(1'b1, 1'b1, 1'b1);
    repeat (2) begin
      step();
      peri_all &= peri_reset;
    end
    chk("glitch_state", int'(state_o), S_PB_LEAD);
    chk("glitch_retry", int'(retry_cnt), 1);
    chk("glitch_peri_held", int'(peri_all), 1);
    wait_model(S_RUN, 200, "glitch_recover");

    // Three consecutive WAIT_UP timeouts into FAULT.
    set_status(1'b0, 1'b0, 1'b0);
    relink_req = 1'b1;
    step();
    wait_model(S_FAULT, 600, "timeout_fault");
    step();
    chk("fault_flag", int'(fault), 1);
    chk("fault_pma_init", int'(u_if.aurora_pma_init), 1);
    chk("fault_reset_pb", int'(u_if.aurora_reset_pb), 1);
    chk("fault_retry", int'(retry_cnt), MAX_RETRY);

    // relink in FAULT, then coincident with a WAIT_UP timeout, then with clk_locked low.
    relink_req = 1'b1;
    step();
    chk("relink_fault_state", int'(state_o), S_PB_LEAD);
    chk("relink_fault_retry", int'(retry_cnt), 0);
    wait_model(S_WAIT_UP, 100, "prio_wait1");
    repeat (TO_N) step();
    wait_model(S_WAIT_UP, 100, "prio_wait2");
    repeat (TO_N - 1) step();
    relink_req = 1'b1;
    step();
    chk("relink_timeout_state", int'(state_o), S_PB_LEAD);
    chk("relink_timeout_retry", int'(retry_cnt), 0);
    repeat (3) step();
    clk_locked = 1'b0;
    relink_req = 1'b1;
    step();
    chk("unlock_over_relink", int'(state_o), S_IDLE);
    clk_locked = 1'b1;

    // Asynchronous reset in PMA_INIT and in RUN.
    wait_model(S_PMA_INIT, 100, "ar_pma");
    repeat (4) step();
    async_reset("ar_pma");
    set_status(1'b1, 1'b1, 1'b1);
    wait_model(S_RUN, 200, "ar_run");
    repeat (3) step();
    async_reset("ar_run");

    // Randomised status, relink and lock activity.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 29) == 0) begin
        if ($urandom_range(0, 3) != 0) set_status(1'b1, 1'b1, 1'b1);
        else set_status(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)));
      end
      if ($urandom_range(0, 249) == 0) relink_req = 1'b1;
      if (!clk_locked) begin
        if ($urandom_range(0, 4) == 0) clk_locked = 1'b1;
      end else if ($urandom_range(0, 599) == 0) begin
        clk_locked = 1'b0;
      end
      step();
    end

    clk_locked = 1'b1;
    repeat (5) step();
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
